// File: rtl/aoc4_grid_loader_pkg.sv
// Shared day-4 grid definitions: loader FSM states, ASCII cell codes and
// default widths for the partial vector and the bank count.
`ifndef AOC4_TX_W
`define AOC4_TX_W 8
`endif
`ifndef AOC4_MACH_N
`define AOC4_MACH_N 4
`endif

package aoc4_grid_loader_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } loader_state_t;

  localparam logic [7:0] CH_ROLL  = 8'h40;
  localparam logic [7:0] CH_EMPTY = 8'h2E;
  localparam logic [7:0] CH_NL    = 8'h0A;

endpackage

// File: rtl/aoc4_grid_loader_bank_route.sv
// Maps a global grid row onto its bank (row mod MACH_N, one-hot) and the
// row address inside that bank (row div MACH_N). Shared with the read side.
module aoc4_bank_route #(
  parameter int unsigned MACH_N      = `AOC4_MACH_N,
  parameter int unsigned BANK_ADDR_W = 8
) (
  input  logic [BANK_ADDR_W+$clog2(MACH_N)-1:0] g_row,
  output logic [MACH_N-1:0]                     bank_sel,
  output logic [BANK_ADDR_W-1:0]                row_addr
);

  localparam int unsigned SEL_W = $clog2(MACH_N);
  localparam int unsigned ROW_W = BANK_ADDR_W + SEL_W;

  // low row bits pick the bank, the remaining bits address within it
  always_comb begin
    bank_sel = '0;
    bank_sel[g_row[SEL_W-1:0]] = 1'b1;
    row_addr = g_row[ROW_W-1:SEL_W];
  end

endmodule

// File: rtl/aoc4_grid_loader.sv
// Day-4 grid loader: packs the ASCII puzzle stream into TX_W-cell partial
// vectors and writes them into the row-interleaved banks.
// Optional roll counter built only when AOC4_LOADER_STATS_EN is defined.
module aoc4_grid_loader
  import aoc4_grid_loader_pkg::*;
#(
  parameter int unsigned TX_W        = `AOC4_TX_W,
  parameter int unsigned MACH_N      = `AOC4_MACH_N,
  parameter int unsigned BANK_ADDR_W = 8,
  parameter int unsigned COL_ADDR_W  = 4
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  in_valid,
  input  logic [7:0]                            in_data,
  input  logic                                  in_last,
  output logic                                  in_ready,
  output logic [MACH_N-1:0]                     bank_write_en,
  input  logic [MACH_N-1:0]                     bank_ack,
  output logic [BANK_ADDR_W-1:0]                row_addr,
  output logic [COL_ADDR_W-1:0]                 col_addr,
  output logic [TX_W-1:0]                       partial_vec,
  output logic                                  pad_en,
  output logic [BANK_ADDR_W+$clog2(MACH_N)-1:0] rows_loaded,
  output logic [COL_ADDR_W+$clog2(TX_W)-1:0]    row_width,
  output logic                                  done,
  output logic                                  err,
  output logic [15:0]                           roll_count
);

  localparam int unsigned BIT_W = $clog2(TX_W);
  localparam int unsigned ROW_W = BANK_ADDR_W + $clog2(MACH_N);
  localparam int unsigned WID_W = COL_ADDR_W + BIT_W;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(TX_W - 1);

  loader_state_t           state, state_n;
  logic [ROW_W-1:0]        g_row, g_row_n;
  logic [COL_ADDR_W-1:0]   col, col_n;
  logic                    col_ovf, col_ovf_n, row_ovf, row_ovf_n;
  logic [BIT_W-1:0]        bit_idx, bit_idx_n;
  logic [TX_W-1:0]         buffer, buf_n;
  logic [WID_W-1:0]        row_cells, row_cells_n, adv_cells;
  logic                    eol_pend, eol_n, last_pend, last_n;
  logic [MACH_N-1:0]       wen_n, route_sel;
  logic [BANK_ADDR_W-1:0]  row_addr_n, route_row;
  logic [COL_ADDR_W-1:0]   col_addr_n;
  logic [TX_W-1:0]         vec_n;
  logic [WID_W-1:0]        row_width_n;
  logic                    done_n, err_n;
  logic                    issue, advance, is_cell, chunk_done;

  aoc4_bank_route #(
    .MACH_N      (MACH_N),
    .BANK_ADDR_W (BANK_ADDR_W)
  ) u_route (
    .g_row    (g_row),
    .bank_sel (route_sel),
    .row_addr (route_row)
  );

  assign in_ready    = (state == ACCUM);
  assign pad_en      = 1'b1;
  assign rows_loaded = g_row;
  assign is_cell     = (in_data == CH_ROLL) || (in_data == CH_EMPTY);
  // a dropped chunk enters ISSUE with no request raised and completes at once
  assign chunk_done  = (bank_write_en == '0) || ((bank_ack & bank_write_en) != '0);

  // next-state, chunk issue and single-cycle row advance
  always_comb begin
    state_n     = state;
    g_row_n     = g_row;
    col_n       = col;
    col_ovf_n   = col_ovf;
    row_ovf_n   = row_ovf;
    bit_idx_n   = bit_idx;
    buf_n       = buffer;
    row_cells_n = row_cells;
    eol_n       = eol_pend;
    last_n      = last_pend;
    wen_n       = bank_write_en;
    row_addr_n  = row_addr;
    col_addr_n  = col_addr;
    vec_n       = partial_vec;
    row_width_n = row_width;
    done_n      = done;
    err_n       = err;
    issue       = 1'b0;
    advance     = 1'b0;
    adv_cells   = row_cells;

    unique case (state)
      ACCUM: begin
        if (in_valid) begin
          last_n = in_last;
          if (is_cell) begin
            buf_n[bit_idx] = (in_data == CH_ROLL);
            bit_idx_n      = bit_idx + BIT_W'(1);
            row_cells_n    = row_cells + WID_W'(1);
          end
          // a full chunk goes out first; a pending last then closes the row
          if (is_cell && bit_idx == LAST_BIT) begin
            issue = 1'b1;
          end else if (in_data == CH_NL || (in_last && row_cells_n != '0)) begin
            eol_n = 1'b1;
            if (bit_idx_n != '0) begin
              issue = 1'b1;
            end else begin
              advance   = 1'b1;
              adv_cells = row_cells_n;
            end
          end else if (in_last) begin
            state_n = DONE;
            done_n  = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (chunk_done) begin
          wen_n     = '0;
          buf_n     = '0;
          bit_idx_n = '0;
          if (col == '1) col_ovf_n = 1'b1;
          else           col_n     = col + COL_ADDR_W'(1);
          if (eol_pend || last_pend) advance = 1'b1;
          else                       state_n = ACCUM;
        end
      end
      DONE: ;
    endcase

    if (issue) begin
      state_n    = ISSUE;
      row_addr_n = route_row;
      col_addr_n = col;
      vec_n      = buf_n;
      if (col_ovf || row_ovf) begin
        wen_n = '0;
        err_n = 1'b1;
      end else begin
        wen_n = route_sel;
      end
    end

    if (advance) begin
      if (row_ovf) begin
        err_n = 1'b1;
      end else begin
        if (g_row == '0)                  row_width_n = adv_cells;
        else if (adv_cells != row_width)  err_n       = 1'b1;
        if (g_row == '1) row_ovf_n = 1'b1;
        else             g_row_n   = g_row + ROW_W'(1);
      end
      col_n       = '0;
      col_ovf_n   = 1'b0;
      eol_n       = 1'b0;
      row_cells_n = '0;
      state_n     = last_n ? DONE : ACCUM;
      done_n      = last_n;
    end
  end

  // state and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ACCUM;
      g_row         <= '0;
      col           <= '0;
      col_ovf       <= 1'b0;
      row_ovf       <= 1'b0;
      bit_idx       <= '0;
      buffer        <= '0;
      row_cells     <= '0;
      eol_pend      <= 1'b0;
      last_pend     <= 1'b0;
      bank_write_en <= '0;
      row_addr      <= '0;
      col_addr      <= '0;
      partial_vec   <= '0;
      row_width     <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      state         <= state_n;
      g_row         <= g_row_n;
      col           <= col_n;
      col_ovf       <= col_ovf_n;
      row_ovf       <= row_ovf_n;
      bit_idx       <= bit_idx_n;
      buffer        <= buf_n;
      row_cells     <= row_cells_n;
      eol_pend      <= eol_n;
      last_pend     <= last_n;
      bank_write_en <= wen_n;
      row_addr      <= row_addr_n;
      col_addr      <= col_addr_n;
      partial_vec   <= vec_n;
      row_width     <= row_width_n;
      done          <= done_n;
      err           <= err_n;
    end
  end

`ifdef AOC4_LOADER_STATS_EN
  logic [15:0] roll_q;
  logic        count_roll;

  assign count_roll = in_valid && in_ready && (in_data == CH_ROLL) && !col_ovf && !row_ovf;
  assign roll_count = roll_q;

  // saturating count of rolls that land in a written chunk
  always_ff @(posedge clock) begin
    if (reset)                          roll_q <= '0;
    else if (count_roll && roll_q != '1) roll_q <= roll_q + 16'd1;
  end
`else
  assign roll_count = '0;
`endif

endmodule

// File: tb/tb_aoc4_grid_loader.sv
// Directed bench for aoc4_grid_loader: byte feeder, auto-acking bank model
// that records every write, and hand-computed expectations per scenario.
module tb_aoc4_grid_loader;

  localparam int unsigned TX_W        = 8;
  localparam int unsigned MACH_N      = 4;
  localparam int unsigned BANK_ADDR_W = 8;
  localparam int unsigned COL_ADDR_W  = 4;

`ifdef AOC4_LOADER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic [3:0]  bank_write_en;
  logic [3:0]  bank_ack;
  logic [7:0]  row_addr;
  logic [3:0]  col_addr;
  logic [7:0]  partial_vec;
  logic        pad_en;
  logic [9:0]  rows_loaded;
  logic [6:0]  row_width;
  logic        done;
  logic        err;
  logic [15:0] roll_count;

  logic [3:0]  stray_ack;
  int unsigned ack_lat;
  logic [3:0]  q_en[$];
  logic [7:0]  q_row[$];
  logic [3:0]  q_col[$];
  logic [7:0]  q_vec[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  aoc4_grid_loader #(
    .TX_W        (TX_W),
    .MACH_N      (MACH_N),
    .BANK_ADDR_W (BANK_ADDR_W),
    .COL_ADDR_W  (COL_ADDR_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_last       (in_last),
    .in_ready      (in_ready),
    .bank_write_en (bank_write_en),
    .bank_ack      (bank_ack),
    .row_addr      (row_addr),
    .col_addr      (col_addr),
    .partial_vec   (partial_vec),
    .pad_en        (pad_en),
    .rows_loaded   (rows_loaded),
    .row_width     (row_width),
    .done          (done),
    .err           (err),
    .roll_count    (roll_count)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // bank model: records each request once, acks after ack_lat cycles
  initial begin : responder
    int unsigned wait_cnt = 0;
    bit          just_acked = 1'b0;
    bank_ack = '0;
    forever begin
      @(negedge clock);
      if (just_acked) begin
        check_val("wen_low_after_ack", bank_write_en, 32'h0);
        just_acked = 1'b0;
      end
      bank_ack = stray_ack;
      if (reset) begin
        wait_cnt = 0;
      end else if (bank_write_en != '0) begin
        if (wait_cnt == 0) begin
          q_en.push_back(bank_write_en);
          q_row.push_back(row_addr);
          q_col.push_back(col_addr);
          q_vec.push_back(partial_vec);
        end
        wait_cnt++;
        if (wait_cnt >= ack_lat) begin
          bank_ack   = bank_write_en | stray_ack;
          wait_cnt   = 0;
          just_acked = 1'b1;
        end
      end
    end
  end

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    q_en.delete();
    q_row.delete();
    q_col.delete();
    q_vec.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int unsigned n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      check_val("send_ready_timeout", in_ready, 32'h1);
      return;
    end
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    @(negedge clock);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_str(input string s, input bit last_on_end);
    for (int unsigned i = 0; i < s.len(); i++)
      send_byte(s[i], last_on_end && (i == s.len() - 1));
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while (!in_ready && !done && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready && !done) check_val("idle_timeout", in_ready, 32'h1);
  endtask

  task automatic expect_write(input string tag, input logic [3:0] en, input logic [7:0] row,
                              input logic [3:0] col, input logic [7:0] vec);
    check_val({tag, "_queued"}, q_en.size() != 0, 32'h1);
    if (q_en.size() == 0) return;
    check_val({tag, "_en"},  q_en.pop_front(),  en);
    check_val({tag, "_row"}, q_row.pop_front(), row);
    check_val({tag, "_col"}, q_col.pop_front(), col);
    check_val({tag, "_vec"}, q_vec.pop_front(), vec);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    stray_ack = '0;
    ack_lat   = 2;
    do_reset();

    // reset state
    check_val("rst_in_ready", in_ready, 32'h1);
    check_val("rst_wen", bank_write_en, 32'h0);
    check_val("rst_row_addr", row_addr, 32'h0);
    check_val("rst_col_addr", col_addr, 32'h0);
    check_val("rst_vec", partial_vec, 32'h0);
    check_val("rst_pad_en", pad_en, 32'h1);
    check_val("rst_rows", rows_loaded, 32'h0);
    check_val("rst_width", row_width, 32'h0);
    check_val("rst_done", done, 32'h0);
    check_val("rst_err", err, 32'h0);
    check_val("rst_roll", roll_count, 32'h0);

    // single 8-cell row, ack after 2 cycles
    send_str("@.@.@@..\n", 1'b0);
    wait_idle();
    expect_write("s1_w0", 4'b0001, 8'd0, 4'd0, 8'h35);
    check_val("s1_nwrites", q_en.size(), 32'd0);
    check_val("s1_rows", rows_loaded, 32'd1);
    check_val("s1_width", row_width, 32'd8);
    check_val("s1_err", err, 32'h0);
    check_val("s1_done", done, 32'h0);

    // three 10-cell rows across banks 0..2
    do_reset();
    for (int unsigned r = 0; r < 3; r++) send_str("@@@@@@@@@@\n", 1'b0);
    wait_idle();
    for (int unsigned r = 0; r < 3; r++) begin
      expect_write("s2_c0", 4'(1 << r), 8'd0, 4'd0, 8'hFF);
      expect_write("s2_c1", 4'(1 << r), 8'd0, 4'd1, 8'h03);
    end
    check_val("s2_width", row_width, 32'd10);
    check_val("s2_rows", rows_loaded, 32'd3);
    check_val("s2_err", err, 32'h0);

    // five rows, in_last on final newline: row 4 wraps to bank0 row 1
    do_reset();
    for (int unsigned r = 0; r < 5; r++) send_str("@.@.@@..\n", r == 4);
    wait_idle();
    for (int unsigned r = 0; r < 4; r++) expect_write("s3_w", 4'(1 << r), 8'd0, 4'd0, 8'h35);
    expect_write("s3_w4", 4'b0001, 8'd1, 4'd0, 8'h35);
    check_val("s3_done", done, 32'h1);
    check_val("s3_in_ready", in_ready, 32'h0);
    check_val("s3_rows", rows_loaded, 32'd5);
    check_val("s3_err", err, 32'h0);

    // width mismatch 8 then 9, loading continues
    do_reset();
    send_str("@@@@@@@@\n", 1'b0);
    wait_idle();
    check_val("s4_err_row0", err, 32'h0);
    send_str("@@@@@@@@@\n", 1'b0);
    wait_idle();
    check_val("s4_err_row1", err, 32'h1);
    check_val("s4_rows_row1", rows_loaded, 32'd2);
    send_str("........\n", 1'b0);
    wait_idle();
    expect_write("s4_r0", 4'b0001, 8'd0, 4'd0, 8'hFF);
    expect_write("s4_r1c0", 4'b0010, 8'd0, 4'd0, 8'hFF);
    expect_write("s4_r1c1", 4'b0010, 8'd0, 4'd1, 8'h01);
    expect_write("s4_r2", 4'b0100, 8'd0, 4'd0, 8'h00);
    check_val("s4_rows", rows_loaded, 32'd3);
    check_val("s4_width", row_width, 32'd8);
    check_val("s4_err_sticky", err, 32'h1);

    // slow ack with a stray ack on bank1 while bank0 waits
    do_reset();
    ack_lat   = 20;
    stray_ack = 4'b0010;
    send_str("@@@@....", 1'b0);
    for (int unsigned c = 0; c < 15; c++) begin
      check_val("s5_hold_stable", {in_ready, bank_write_en, col_addr, partial_vec},
                {1'b0, 4'b0001, 4'h0, 8'h0F});
      @(negedge clock);
    end
    stray_ack = '0;
    send_str("\n", 1'b0);
    wait_idle();
    expect_write("s5_w0", 4'b0001, 8'd0, 4'd0, 8'h0F);
    check_val("s5_nwrites", q_en.size(), 32'd0);
    check_val("s5_rows", rows_loaded, 32'd1);

    // reset while a request is outstanding drops write_en
    send_str("@@@@@@@@", 1'b0);
    check_val("s5b_wen_pending", bank_write_en, 32'b0010);
    reset = 1'b1;
    @(negedge clock);
    check_val("s5b_wen_drop_on_reset", bank_write_en, 32'h0);
    ack_lat = 1;
    do_reset();

    // '\r' ignored, roll counting
    send_byte(8'h40, 1'b0);
    send_byte(8'h0D, 1'b0);
    send_str(".@\n", 1'b1);
    wait_idle();
    expect_write("s6_w0", 4'b0001, 8'd0, 4'd0, 8'h05);
    check_val("s6_roll", roll_count, STATS ? 32'd2 : 32'd0);
    check_val("s6_width", row_width, 32'd3);
    check_val("s6_done", done, 32'h1);
    check_val("s6_err", err, 32'h0);

    // empty row and a final row without trailing newline
    do_reset();
    ack_lat = 2;
    send_str("@@\n", 1'b0);
    send_str("\n", 1'b0);
    send_str("@@", 1'b1);
    wait_idle();
    expect_write("s7_r0", 4'b0001, 8'd0, 4'd0, 8'h03);
    expect_write("s7_r2", 4'b0100, 8'd0, 4'd0, 8'h03);
    check_val("s7_nwrites", q_en.size(), 32'd0);
    check_val("s7_rows", rows_loaded, 32'd3);
    check_val("s7_err", err, 32'h1);
    check_val("s7_done", done, 32'h1);

    // column overflow: 17 chunks in one row, the last is dropped
    do_reset();
    for (int unsigned i = 0; i < 136; i++) send_byte(8'h40, 1'b0);
    send_byte(8'h0A, 1'b1);
    wait_idle();
    for (int unsigned i = 0; i < 16; i++) expect_write("s8_w", 4'b0001, 8'd0, 4'(i), 8'hFF);
    check_val("s8_nwrites", q_en.size(), 32'd0);
    check_val("s8_err", err, 32'h1);
    check_val("s8_done", done, 32'h1);
    check_val("s8_rows", rows_loaded, 32'd1);
    check_val("s8_roll", roll_count, STATS ? 32'd128 : 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aoc4_grid_loader.md
Name: aoc4_grid_loader

Overview:
- Upstream feeder for the per-bank memory controllers of the day-4 grid engine.
- Consumes the ASCII puzzle stream one byte at a time: '@' is a roll (1), '.' is empty (0), '\n' ends a row.
- Packs cells into TX_W-bit partial vectors and writes each one into bank (row mod MACH_N), bank row (row div MACH_N), column chunk col.
- Uses the bank's write_en/ack handshake and reports grid dimensions and completion.

Parameters:
- TX_W, 8, cells per partial vector; equals the bank TX data width.
- MACH_N, 4, number of banks; power of two.
- BANK_ADDR_W, 8, bank row address width.
- COL_ADDR_W, 4, column-chunk address width.

Ports:
- clock  in  1  system clock
- reset  in  1  reset input
- in_valid  in  1  byte available
- in_data  in  8  ASCII byte
- in_last  in  1  qualifies the final byte of the stream
- in_ready  out  1  loader accepts a byte this cycle
- bank_write_en  out  MACH_N  one-hot write request to the target bank
- bank_ack  in  MACH_N  per-bank ack
- row_addr  out  BANK_ADDR_W  bank row address
- col_addr  out  COL_ADDR_W  column chunk index
- partial_vec  out  TX_W  packed cells; bit i = column col*TX_W+i
- pad_en  out  1  border-pad shift request; constant 1
- rows_loaded  out  BANK_ADDR_W+log2(MACH_N)  completed rows
- row_width  out  COL_ADDR_W+log2(TX_W)  cells per row, latched from row 0
- done  out  1  sticky; load complete
- err  out  1  sticky; width mismatch or address overflow
- roll_count  out  16  number of '@' cells loaded (optional feature)

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clock.
- Reset values: FSM=ACCUM; in_ready=1; bank_write_en=0; row_addr, col_addr, partial_vec, rows_loaded, row_width, roll_count all 0; done=0; err=0. pad_en is always 1.
- Global row counter g_row. Bank select = g_row[log2(MACH_N)-1:0]; row_addr = g_row >> log2(MACH_N).
- State ACCUM (in_ready=1). A byte is accepted when in_valid && in_ready.
  - '@' or '.': write the cell into shift buffer bit bit_idx and increment bit_idx. If bit_idx was TX_W-1, go to ISSUE.
  - '\n': set eol_pend. If bit_idx>0, go to ISSUE (unfilled upper bits are 0). Otherwise advance the row in place.
  - Any other byte (e.g. '\r'): consumed and ignored.
  - in_last on an accepted byte sets last_pend. A final row without a trailing '\n' is treated as if '\n' followed.
- State ISSUE (in_ready=0).
  - Registered outputs are loaded and held stable: bank_write_en, row_addr, col_addr, partial_vec.
  - Wait for bank_ack of the selected bank; acks from other banks are ignored.
  - On the edge where that ack is sampled high, clear bank_write_en. It must be low in the following cycle so the bank does not write back a second time.
  - Then clear the buffer and bit_idx, and increment col.
  - If eol_pend: advance the row. Else if last_pend: advance the row. Else return to ACCUM.
- Row advance (single cycle, no extra state):
  - Cells in the row = col*TX_W + bit_idx, taken before clearing.
  - Row 0: latch the count into row_width.
  - Rows >0: if the count differs from row_width, set err. Loading continues.
  - Then g_row++, rows_loaded++, col=0, eol_pend=0.
  - If last_pend: go to DONE.
- State DONE: in_ready=0 and done=1. Remain there until reset.
- Overflow:
  - If col would exceed 2^COL_ADDR_W-1, or g_row would exceed its counter range, set err.
  - The overflowing chunk or row is dropped; no write is issued.
  - The stream is still consumed until in_last.
- Empty row ('\n' at col=0, bit_idx=0): no write is issued; the row is counted with width 0, so a mismatch sets err.
- Back-to-back bytes are accepted at 1 per cycle in ACCUM. Each chunk costs at least one byte cycle plus the bank latency, typically 2–3 cycles.
- Reset mid-ISSUE: bank_write_en drops on the reset edge. The bank is reset by the same signal, so no partial transaction survives.

Optional Feature:
- Macro: AOC4_LOADER_STATS_EN.
- Defined: roll_count increments on every accepted '@' that is not dropped, and saturates at 16'hFFFF.
- Undefined: roll_count is tied to 0 and no counter logic is built.

Decomposition:
- Shared aoc4 package:
  - loader_state_t enum {ACCUM, ISSUE, DONE}
  - character constants CH_ROLL=8'h40, CH_EMPTY=8'h2E, CH_NL=8'h0A
  - width macros for TX_W and MACH_N
- Sub-module aoc4_bank_route (purely combinational):
  - input g_row
  - outputs the one-hot bank select and row_addr
  - shared with the read-side scanner.

Test Plan:
- "@.@.@@..\n": one write to bank0, row 0, col 0, vec=8'h35. Ack after 2 cycles gives bank_write_en low the next cycle, rows_loaded=1, row_width=8.
- 3 rows of "@@@@@@@@@@\n" (10 cells): writes go to banks 0,1,2, each col0=8'hFF then col1=8'h03. row_width=10, err=0.
- 5 rows with in_last on the final '\n': the 5th row goes to bank0, row_addr=1. done=1 and in_ready=0 afterwards.
- Row widths 8 then 9: err=1 after row 1. Loading continues and rows_loaded=2.
- bank_ack held low 20 cycles: outputs stay stable and in_ready=0. Ack on bank1 while bank0 is selected is ignored.
- With the feature, "@\r.@\n" with in_last: roll_count=2, '\r' ignored, vec=8'h05. Without the feature, roll_count=0.
